ram_bus_master: RTL and testbench

Bus-initiator block that drives the RAM chip-select/read/ready interface on behalf of the processor core. It accepts one single-word read or write request per transaction from the core, sequences cs_ram/read/address/data on the shared 16-bit tri-state data bus, tracks the RAM's ready_ram low-then-high handshake, and returns read data with a one-cycle completion pulse. It sits between the core's load/store unit and the RAM, and owns the bus drive direction.

---
 rtl/ram_bus_master.sv | 143 ++++++++++++++
 tb/tb_ram_bus_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// Single-word RAM bus initiator: cs_ram/read/address sequencing with ready_ram handshake.
// Optional abort on stalled RAM handshake when MEM_TIMEOUT_EN is defined.
module ram_bus_master #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  cs_ram,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] address,
  inout  tri   [DATA_WIDTH-1:0] data,
  input  logic                  ready_ram
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t                state_q, state_n;
  logic                  cs_n, read_n, busy_n, done_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n, rdata_n;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_n;
  logic          err_q, err_n;
  logic          abort;

  assign abort = (state_q != IDLE) &&
                 (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

  // only write cycles own the bus
  assign data = (cs_ram && !read) ? wdata_q : 'z;

  always_comb begin
    state_n = state_q;
    cs_n    = cs_ram;
    read_n  = read;
    addr_n  = address;
    busy_n  = busy;
    done_n  = 1'b0;
    rdata_n = rdata;
    we_n    = we_q;
    wdata_n = wdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_n   = cnt_q;
    err_n   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cs_n   = 1'b0;
        read_n = 1'b1;
        if (req) begin
          we_n    = we;
          wdata_n = wdata;
          addr_n  = addr;
          cs_n    = 1'b1;
          read_n  = ~we;
          busy_n  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (!ready_ram) state_n = WAIT;
      end
      WAIT: begin
        if (ready_ram) begin
          if (!we_q) rdata_n = data;
          cs_n    = 1'b0;
          read_n  = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (state_q == IDLE) cnt_n = '0;
    else cnt_n = cnt_q + 1'b1;
    // a genuine completion on the final cycle wins over the abort
    if (abort && state_n != IDLE) begin
      cs_n    = 1'b0;
      read_n  = 1'b1;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      err_n   = 1'b1;
      state_n = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cs_ram  <= 1'b0;
      read    <= 1'b1;
      address <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cs_ram  <= cs_n;
      read    <= read_n;
      address <= addr_n;
      busy    <= busy_n;
      done    <= done_n;
      rdata   <= rdata_n;
      we_q    <= we_n;
      wdata_q <= wdata_n;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_n;
      err_q   <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural RAM with adjustable handshake delays,
// expected memory contents and latencies computed from the protocol rules.
module tb_ram_bus_master;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, err, cs_ram, read;
  logic [DW-1:0] rdata;
  logic [AW-1:0] address;
  tri1  [DW-1:0] data;
  logic          ready_ram = 1'b1;

  logic          ram_oe = 1'b0;
  logic [DW-1:0] ram_q = '0;
  bit   [DW-1:0] mem [0:255];

  int pre_dly = 0;
  int post_dly = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  bit   [DW-1:0] exp_mem [int];
  logic [DW-1:0] exp_rdata = '0;

  assign data = (ram_oe && cs_ram && read) ? ram_q : 'z;

  ram_bus_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .cs_ram   (cs_ram),
    .read     (read),
    .address  (address),
    .data     (data),
    .ready_ram(ready_ram)
  );

  always #5 clk = ~clk;

  // RAM: drop ready pre_dly cycles after seeing cs, hold low post_dly extra
  int   r_st = 0;
  int   r_cnt = 0;
  logic s_cs, s_rd;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_d;
  always begin
    @(posedge clk);
    s_cs = cs_ram;
    s_rd = read;
    s_a  = address;
    s_d  = data;
    #1;
    if (!rst_n) begin
      r_st = 0;
      r_cnt = 0;
      ready_ram = 1'b1;
      ram_oe = 1'b0;
    end else begin
      case (r_st)
        0: begin
          if (s_cs) begin
            if (r_cnt >= pre_dly) begin
              ready_ram = 1'b0;
              r_cnt = 0;
              r_st = 1;
              if (s_rd) begin
                ram_q = mem[s_a[7:0]];
                ram_oe = 1'b1;
              end
            end else r_cnt++;
          end else r_cnt = 0;
        end
        1: begin
          if (r_cnt >= post_dly) begin
            ready_ram = 1'b1;
            if (!s_rd) mem[s_a[7:0]] = s_d;
            r_cnt = 0;
            r_st = 2;
          end else r_cnt++;
        end
        default: begin
          if (!s_cs) begin
            r_st = 0;
            ram_oe = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic released();
    return (data === {DW{1'bz}}) || (data === {DW{1'b1}});
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : '0;
  endfunction

  // caller is 1 time unit after a rising edge with the master idle
  task automatic txn(input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int pre, input int post);
    int n;
    bit stable;
    pre_dly = pre;
    post_dly = post;
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_cs", cs_ram, 1);
    chk("acc_read", read, !w);
    chk("acc_addr", address, a);
    if (w) chk("acc_wdata", data, d);
    n = 0;
    stable = 1'b1;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!done && (cs_ram !== 1'b1 || address !== a ||
                    (w && data !== d)))
        stable = 1'b0;
    end
    if (w) exp_mem[int'(a)] = d;
    else exp_rdata = model_rd(a);
    chk("latency", n, 3 + pre + post);
    chk("bus_stable", stable, 1);
    chk("end_cs", cs_ram, 0);
    chk("end_read", read, 1);
    chk("end_busy", busy, 0);
    chk("end_released", released(), 1);
    chk("end_rdata", rdata, exp_rdata);
    chk("end_err", err, 0);
    @(posedge clk);
    #1;
    chk("done_once", done, 0);
    chk("addr_held", address, a);
  endtask

  initial begin
    int cyc, nd, k;
    int dc[$];
    bit pb;
    logic [AW-1:0] ba [3];
    logic [DW-1:0] bd [3];
    bit bw [3];
    logic [DW-1:0] d;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cs", cs_ram, 0);
    chk("rst_read", read, 1);
    chk("rst_addr", address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_released", released(), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    txn(1'b1, 16'h0005, 16'hA5A5, 0, 0);
    chk("ram_mem5", mem[5], 16'hA5A5);
    txn(1'b0, 16'h0005, 16'h0000, 0, 0);
    chk("rd_back", rdata, 16'hA5A5);

    // back-to-back with req held high
    ba = '{16'h0001, 16'h0002, 16'h0001};
    bd = '{16'h1111, 16'h2222, 16'h0000};
    bw = '{1'b1, 1'b1, 1'b0};
    pre_dly = 0;
    post_dly = 0;
    cyc = 0;
    nd = 0;
    k = 0;
    pb = 1'b0;
    req = 1'b1;
    we = bw[0];
    addr = ba[0];
    wdata = bd[0];
    while (nd < 3 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !pb) begin
        k++;
        if (k < 3) begin
          we = bw[k];
          addr = ba[k];
          wdata = bd[k];
        end else req = 1'b0;
      end
      if (done) begin
        dc.push_back(cyc);
        nd++;
      end
      pb = busy;
    end
    req = 1'b0;
    exp_mem[1] = 16'h1111;
    exp_mem[2] = 16'h2222;
    exp_rdata = model_rd(16'h0001);
    chk("b2b_count", nd, 3);
    if (dc.size() == 3) begin
      chk("b2b_gap1", dc[1] - dc[0], 4);
      chk("b2b_gap2", dc[2] - dc[1], 4);
    end
    chk("b2b_rdata", rdata, exp_rdata);
    chk("b2b_mem2", mem[2], 16'h2222);
    @(posedge clk);
    #1;

    txn(1'b1, 16'h0006, 16'hBEEF, 5, 3);
    txn(1'b0, 16'h0006, 16'h0000, 5, 3);

    repeat (20) begin
      d = DW'($urandom);
      if (d == {DW{1'b1}}) d = '0;
      txn(1'($urandom_range(1)), AW'($urandom_range(7)), d,
          $urandom_range(2), $urandom_range(2));
    end

    // reset while the master sits in WAIT: the write must be lost
    txn(1'b1, 16'h0009, 16'h1234, 0, 0);
    pre_dly = 0;
    post_dly = 6;
    req = 1'b1;
    we = 1'b1;
    addr = 16'h0009;
    wdata = 16'h5A5A;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", cs_ram, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_read", read, 1);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_released", released(), 1);
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 16'h0009, 16'h0000, 0, 0);
    chk("post_rst_read", rdata, 16'h1234);

`ifdef MEM_TIMEOUT_EN
    pre_dly = 1000;
    req = 1'b1;
    we = 1'b0;
    addr = 16'h0002;
    @(posedge clk);
    #1;
    req = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("to_latency", cyc, 16);
    chk("to_err", err, 1);
    chk("to_cs", cs_ram, 0);
    chk("to_rdata", rdata, exp_rdata);
    pre_dly = 0;
    @(posedge clk);
    #1;
    chk("to_err_once", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
